// File: rtl/clock_controller.sv
// ---------------------------------------------------------------------------
// clock_controller
//
// Processor clock sequencer: programmable divider with run / halt /
// single-step control. Replaces a free-running divider between the board
// clock and the processor so debug/IO logic can stop the processor on a
// period boundary and advance it one period at a time.
//
// Parameters
//   DIV_WIDTH    width of the divisor and the period counter
//   DEFAULT_DIV  divisor loaded at reset
//   START_RUN    1: come out of reset running, 0: come out of reset halted
//
// Ports
//   clock_in     board clock, all logic on its rising edge
//   reset        asynchronous, active-low reset
//   div_load     one-cycle strobe, capture div_value as the pending divisor
//   div_value    new divisor (values below 2 are clamped to 2)
//   run_req      start / resume free running
//   halt_req     stop at the end of the current period
//   step_req     run exactly one period from IDLE
//   clock_out    divided clock to the processor (registered)
//   tick         high on the last clock_in cycle of each period
//   halted       high while the sequencer is IDLE
//   state        IDLE=0, RUN=1, STEP=2, DRAIN=3
//   div_active   divisor used by the period in progress
//
// Optional build macro CYCLE_COUNT_EN adds:
//   cycle_clr    synchronous clear of cycle_count (wins over increment)
//   cycle_count  32-bit count of completed periods (ticks), wraps to 0
// ---------------------------------------------------------------------------
module clock_controller #(
  parameter int unsigned          DIV_WIDTH   = 28,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 28'd60000,
  parameter bit                   START_RUN   = 1'b1
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 run_req,
  input  logic                 halt_req,
  input  logic                 step_req,
  output logic                 clock_out,
  output logic                 tick,
  output logic                 halted,
  output logic [1:0]           state,
  output logic [DIV_WIDTH-1:0] div_active
`ifdef CYCLE_COUNT_EN
  ,
  input  logic                 cycle_clr,
  output logic [31:0]          cycle_count
`endif
);

  // state | meaning
  // IDLE  | halted: counter held at 0, clock_out held low
  // RUN   | free running, periods back to back
  // STEP  | single period started from IDLE, returns to IDLE on wrap
  // DRAIN | halt pending: finish the current period, then IDLE

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE     = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_TWO     = DIV_WIDTH'(2);
  localparam state_t               RESET_STATE = START_RUN ? ST_RUN : ST_IDLE;

  state_t               state_q;
  state_t               state_d;
  logic [DIV_WIDTH-1:0] counter_q;
  logic [DIV_WIDTH-1:0] counter_d;
  logic [DIV_WIDTH-1:0] div_pend_q;
  logic                 pend_flag_q;
  logic [DIV_WIDTH-1:0] div_next;
  logic [DIV_WIDTH-1:0] div_clamped;
  logic                 clock_out_d;
  logic                 wrap;
  logic                 apply;

  // Last cycle of a period; only meaningful while a period is in progress.
  assign wrap = (state_q != ST_IDLE) && (counter_q == (div_active - DIV_ONE));

  // A pending divisor only takes effect between periods, so a period in
  // progress never changes length.
  assign apply       = pend_flag_q && (wrap || (state_q == ST_IDLE));
  assign div_next    = apply ? div_pend_q : div_active;
  assign div_clamped = (div_value < DIV_TWO) ? DIV_TWO : div_value;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // In STEP and DRAIN the wrap cycle ends the period and wins over a
  // simultaneous run_req; the period is complete at that point.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run_req) begin
          state_d = ST_RUN;
        end else if (step_req) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = wrap ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_STEP, ST_DRAIN: begin
        if (wrap) begin
          state_d = ST_IDLE;
        end else if (run_req) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    tick   = wrap;
    halted = (state_q == ST_IDLE);
  end

  assign state = state_q;

  // -------------------------------------------------------------------------
  // Period counter and divided clock
  // clock_out is computed from the next counter/state/divisor so that the
  // registered output lines up with the counter value of the same cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    if ((state_q == ST_IDLE) || wrap) begin
      counter_d = '0;
    end else begin
      counter_d = counter_q + DIV_ONE;
    end
  end

  assign clock_out_d = (state_d != ST_IDLE) && (counter_d >= (div_next >> 1));

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      counter_q <= '0;
      clock_out <= 1'b0;
    end else begin
      counter_q <= counter_d;
      clock_out <= clock_out_d;
    end
  end

  // -------------------------------------------------------------------------
  // Divisor update
  // A load coinciding with an apply lands in the pending register after the
  // old pending value has moved to div_active, and stays pending.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      div_active  <= DEFAULT_DIV;
      div_pend_q  <= DEFAULT_DIV;
      pend_flag_q <= 1'b0;
    end else begin
      if (apply) begin
        div_active <= div_pend_q;
      end
      if (div_load) begin
        div_pend_q  <= div_clamped;
        pend_flag_q <= 1'b1;
      end else if (apply) begin
        pend_flag_q <= 1'b0;
      end
    end
  end

`ifdef CYCLE_COUNT_EN
  // -------------------------------------------------------------------------
  // Completed-period counter
  // -------------------------------------------------------------------------
  logic [31:0] cycle_count_q;

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      cycle_count_q <= '0;
    end else if (cycle_clr) begin
      cycle_count_q <= '0;
    end else if (tick) begin
      cycle_count_q <= cycle_count_q + 32'd1;
    end
  end

  assign cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_clock_controller.sv
module tb_clock_controller;

  localparam int DW = 28;

  logic          clock_in = 1'b0;
  logic          reset = 1'b0;
  logic          div_load = 1'b0;
  logic [DW-1:0] div_value = '0;
  logic          run_req = 1'b0;
  logic          halt_req = 1'b0;
  logic          step_req = 1'b0;
  logic          clock_out;
  logic          tick;
  logic          halted;
  logic [1:0]    state;
  logic [DW-1:0] div_active;
`ifdef CYCLE_COUNT_EN
  logic          cycle_clr = 1'b0;
  logic [31:0]   cycle_count;
`endif

  clock_controller #(
    .DIV_WIDTH  (DW),
    .DEFAULT_DIV(28'd4),
    .START_RUN  (1'b1)
  ) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .div_load  (div_load),
    .div_value (div_value),
    .run_req   (run_req),
    .halt_req  (halt_req),
    .step_req  (step_req),
    .clock_out (clock_out),
    .tick      (tick),
    .halted    (halted),
    .state     (state),
    .div_active(div_active)
`ifdef CYCLE_COUNT_EN
    ,
    .cycle_clr  (cycle_clr),
    .cycle_count(cycle_count)
`endif
  );

  always #5 clock_in = ~clock_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: period position, mode, divisor bookkeeping.
  // m_state uses 0 idle, 1 run, 2 step, 3 drain.
  int m_state;
  int m_pos;
  int m_div;
  int m_pend;
  bit m_pflag;
`ifdef CYCLE_COUNT_EN
  logic [31:0] m_cc;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit m_last();
    return (m_state != 0) && (m_pos == m_div - 1);
  endfunction

  task automatic model_reset();
    m_state = 1;
    m_pos   = 0;
    m_div   = 4;
    m_pend  = 4;
    m_pflag = 0;
`ifdef CYCLE_COUNT_EN
    m_cc = '0;
`endif
  endtask

  task automatic check_outputs();
    chk("tick", 32'(tick), 32'(m_last()));
    chk("clock_out", 32'(clock_out), 32'((m_state != 0) && (m_pos >= m_div / 2)));
    chk("state", 32'(state), m_state);
    chk("halted", 32'(halted), 32'(m_state == 0));
    chk("div_active", 32'(div_active), m_div);
`ifdef CYCLE_COUNT_EN
    chk("cycle_count", cycle_count, m_cc);
`endif
  endtask

  task automatic model_step(input bit r, input bit h, input bit s, input bit l, input int v);
    bit last;
    bit take;
    int ns;
    last = m_last();
    take = m_pflag && (last || m_state == 0);
    ns   = m_state;
    if (m_state == 0) begin
      if (r) ns = 1;
      else if (s) ns = 2;
    end else if (m_state == 1) begin
      if (h) ns = last ? 0 : 3;
    end else begin
      if (last) ns = 0;
      else if (r) ns = 1;
    end
`ifdef CYCLE_COUNT_EN
    if (cycle_clr) m_cc = '0;
    else if (last) m_cc = m_cc + 32'd1;
`endif
    m_pos = (m_state == 0 || last) ? 0 : m_pos + 1;
    if (take) begin
      m_div   = m_pend;
      m_pflag = 0;
    end
    if (l) begin
      m_pend  = (v < 2) ? 2 : v;
      m_pflag = 1;
    end
    m_state = ns;
  endtask

  // Called at a falling edge: check, drive inputs for the next rising edge.
  task automatic cycle(input bit r, input bit h, input bit s, input bit l, input int v);
    check_outputs();
    run_req   = r;
    halt_req  = h;
    step_req  = s;
    div_load  = l;
    div_value = DW'(v);
    model_step(r, h, s, l, v);
    @(negedge clock_in);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic wait_pos(input int st, input int pos);
    for (int i = 0; i < 64; i++) begin
      if (m_state == st && m_pos == pos) break;
      cycle(0, 0, 0, 0, 0);
    end
    if (!(m_state == st && m_pos == pos)) chk("wait_pos_timeout", 0, 1);
  endtask

  task automatic wait_div(input int d);
    for (int i = 0; i < 64; i++) begin
      if (m_div == d) break;
      cycle(0, 0, 0, 0, 0);
    end
    if (m_div != d) chk("wait_div_timeout", 0, 1);
  endtask

  // Cycles up to and including the next tick, and how many were high.
  task automatic measure(output int len, output int highs);
    bit t;
    len   = 0;
    highs = 0;
    for (int i = 0; i < 64; i++) begin
      highs += int'(clock_out);
      len++;
      t = tick;
      cycle(0, 0, 0, 0, 0);
      if (t) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat8;
    logic [5:0] pat6;
    int         cnt;
    int         tks;
    int         len;
    int         highs;

    // Reset values
    model_reset();
    @(negedge clock_in);
    @(negedge clock_in);
    chk("rst_clock_out", 32'(clock_out), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_state", 32'(state), 1);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_div", 32'(div_active), 4);
    reset = 1'b1;

    // Free running at div 4: 0,0,1,1 with one tick per period
    pat8 = '0;
    tks  = 0;
    for (int i = 0; i < 8; i++) begin
      pat8 = {pat8[6:0], clock_out};
      tks += int'(tick);
      cycle(0, 0, 0, 0, 0);
    end
    chk("run_pattern", 32'(pat8), 32'h33);
    chk("run_ticks", tks, 2);

    // Asynchronous reset mid-period, counter at 2 (clock_out high)
    wait_pos(1, 2);
    chk("pre_reset_clk", 32'(clock_out), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_clk", 32'(clock_out), 0);
    chk("async_rst_state", 32'(state), 1);
    chk("async_rst_tick", 32'(tick), 0);
    @(negedge clock_in);
    reset = 1'b1;
    model_reset();

    // Halt mid-period: drain, then idle
    wait_pos(1, 1);
    cycle(0, 1, 0, 0, 0);
    chk("drain_state", 32'(state), 3);
    idle(2);
    chk("halt_idle_state", 32'(state), 0);
    chk("halt_idle_halted", 32'(halted), 1);
    idle(3);

    // Halt on the wrap cycle goes straight to idle
    cycle(1, 0, 0, 0, 0);
    wait_pos(1, 3);
    cycle(0, 1, 0, 0, 0);
    chk("halt_on_wrap", 32'(state), 0);

    // Divisor load in idle applies next cycle, then single step at div 6
    cycle(0, 0, 0, 1, 6);
    idle(2);
    chk("idle_apply", 32'(div_active), 6);
    cycle(0, 0, 1, 0, 0);
    cnt  = 0;
    tks  = 0;
    pat6 = '0;
    for (int i = 0; i < 8; i++) begin
      if (state == 2'd2) begin
        cnt++;
        pat6 = {pat6[4:0], clock_out};
      end
      tks += int'(tick);
      cycle(0, 0, 0, 0, 0);
    end
    chk("step_cycles", cnt, 6);
    chk("step_pattern", 32'(pat6), 32'h07);
    chk("step_ticks", tks, 1);
    chk("step_back_idle", 32'(state), 0);

    // run_req beats step_req in idle
    cycle(1, 0, 1, 0, 0);
    chk("run_over_step", 32'(state), 1);

    // Divisor change mid-period does not stretch the current period
    cycle(0, 0, 0, 1, 4);
    wait_div(4);
    wait_pos(1, 1);
    cycle(0, 0, 0, 1, 10);
    measure(len, highs);
    chk("cur_period_rest", len, 2);
    measure(len, highs);
    chk("new_period_len", len, 10);
    chk("new_period_high", highs, 5);

    // Divisor 0 clamps to 2
    cycle(0, 0, 0, 1, 0);
    measure(len, highs);
    measure(len, highs);
    chk("clamp_len", len, 2);
    chk("clamp_high", highs, 1);
    chk("clamp_div", 32'(div_active), 2);

`ifdef CYCLE_COUNT_EN
    wait_pos(1, 0);
    cycle_clr = 1'b1;
    cycle(0, 0, 0, 0, 0);
    cycle_clr = 1'b0;
    idle(10);
    chk("cc_five", cycle_count, 5);
    cycle_clr = 1'b1;
    chk("cc_tick_now", 32'(tick), 1);
    cycle(0, 0, 0, 0, 0);
    cycle_clr = 1'b0;
    chk("cc_clr_tick", cycle_count, 0);
    force dut.cycle_count_q = 32'hFFFF_FFFF;
    #1 release dut.cycle_count_q;
    m_cc = 32'hFFFF_FFFF;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("cc_wrap", cycle_count, 0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
`ifdef CYCLE_COUNT_EN
      cycle_clr = ($urandom_range(0, 29) == 0);
`endif
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 14) == 0),
            int'($urandom_range(0, 12)));
    end
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
